// File: rtl/fsm_in_tx_pkg.sv
// Shared types and constants for the FSM `in` transmitter.
// Queue entries are packed as {sym, rep}, with sym in the upper bits.
package fsm_in_pkg;

   localparam int SYM_W = 2;
   localparam logic [SYM_W-1:0] IDLE_SYM_DEF = 2'b00;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_PLAY = 1'b1;

   typedef enum logic {
      IDLE = ST_IDLE,
      PLAY = ST_PLAY
   } state_t;

endpackage

// File: rtl/fsm_in_tx_sym_fifo.sv
// Synchronous FIFO. A write is visible at the head one cycle later; there is no bypass.
// Occupancy is tracked separately from the pointers, so full and empty never alias.
module sym_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage holds no control state, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fsm_in_tx.sv
// Replays queued (sym, rep) entries onto fsm_in for rep+1 cycles each, back-to-back.
// A push reaches fsm_in two edges later. s_ready drops when the FIFO is full; stall freezes playback.
module fsm_in_tx
   import fsm_in_pkg::*;
#(
   parameter int               DEPTH    = 8,
   parameter int               REP_W    = 4,
   parameter logic [SYM_W-1:0] IDLE_SYM = IDLE_SYM_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [SYM_W-1:0]         s_sym,
   input  logic [REP_W-1:0]         s_rep,
   input  logic                     stall,
   output logic [SYM_W-1:0]         fsm_in,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int ENT_W = SYM_W + REP_W;

   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [ENT_W-1:0] head;
   logic [SYM_W-1:0] head_sym;
   logic [REP_W-1:0] head_rep;

   state_t           state, state_nx;
   logic [REP_W-1:0] rem, rem_nx;
   logic [SYM_W-1:0] sym_nx;
   logic             done_nx;

   assign s_ready  = !full;
   assign push     = s_valid && s_ready;
   assign head_sym = head[ENT_W-1 -: SYM_W];
   assign head_rep = head[REP_W-1:0];

   sym_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data ({s_sym, s_rep}),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         rem    <= '0;
         fsm_in <= IDLE_SYM;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         rem    <= rem_nx;
         fsm_in <= sym_nx;
         busy   <= (state_nx == PLAY);
         done   <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      rem_nx   = rem;
      sym_nx   = fsm_in;
      done_nx  = 1'b0;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            sym_nx = IDLE_SYM;
            if (!empty && !stall) begin
               pop      = 1'b1;
               sym_nx   = head_sym;
               rem_nx   = head_rep;
               state_nx = PLAY;
            end
         end
         PLAY: begin
            if (!stall) begin
               if (rem != '0) begin
                  rem_nx = rem - 1'b1;
               end else if (!empty) begin
                  // Chain straight into the next entry so the FSM sees no idle gap.
                  pop    = 1'b1;
                  sym_nx = head_sym;
                  rem_nx = head_rep;
               end else begin
                  sym_nx   = IDLE_SYM;
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fsm_in_tx.sv
// Bench for fsm_in_tx: directed vector table, hand-written corner sequences, randomized run vs. a queue model.
module tb_fsm_in_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [1:0] s_sym = 2'b00;
   logic [3:0] s_rep = 4'd0;
   logic       stall = 1'b0;
   logic [1:0] fsm_in;
   logic       busy;
   logic       done;
   logic [3:0] level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fsm_in_tx #(
      .DEPTH    (8),
      .REP_W    (4),
      .IDLE_SYM (2'b00)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_sym   (s_sym),
      .s_rep   (s_rep),
      .stall   (stall),
      .fsm_in  (fsm_in),
      .busy    (busy),
      .done    (done),
      .level   (level)
   );

   typedef struct {
      logic       rst;
      logic       vld;
      logic [1:0] sym;
      logic [3:0] rep;
      logic       stl;
      logic [1:0] e_in;
      logic       e_busy;
      logic       e_done;
      int         e_level;
      logic       e_ready;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic rst, input logic vld, input logic [1:0] sym,
                               input logic [3:0] rep, input logic stl, input logic [1:0] e_in,
                               input logic e_busy, input logic e_done, input int e_level,
                               input logic e_ready);
      vec_t v;
      v.rst = rst; v.vld = vld; v.sym = sym; v.rep = rep; v.stl = stl;
      v.e_in = e_in; v.e_busy = e_busy; v.e_done = e_done; v.e_level = e_level; v.e_ready = e_ready;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply inputs ahead of the edge, then settle past it before sampling.
   task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic [3:0] rp,
                        input logic st);
      reset = r; s_valid = v; s_sym = s; s_rep = rp; stall = st;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int e_in, input int e_busy, input int e_done,
                          input int e_level, input int e_ready);
      chk({tag, ".fsm_in"}, fsm_in, e_in);
      chk({tag, ".busy"},   busy,   e_busy);
      chk({tag, ".done"},   done,   e_done);
      chk({tag, ".level"},  level,  e_level);
      chk({tag, ".s_ready"}, s_ready, e_ready);
   endtask

   // Reference model: the FIFO as a queue of {sym,rep}, the current entry expanded
   // into the list of symbol repeats still owed after the one now on fsm_in.
   logic [5:0] m_fifo[$];
   logic [1:0] m_stream[$];
   logic [1:0] m_out = 2'b00;
   bit         m_active = 0;
   bit         m_done = 0;

   function automatic void model_step(input logic r, input logic v, input logic [1:0] s,
                                      input logic [3:0] rp, input logic st);
      logic [5:0] e;
      bit can_push;
      if (r) begin
         m_fifo.delete(); m_stream.delete();
         m_out = 2'b00; m_active = 0; m_done = 0;
         return;
      end
      can_push = v && (m_fifo.size() < 8);
      m_done = 0;
      if (!st) begin
         if (m_active && m_stream.size() > 0) begin
            m_out = m_stream.pop_front();
         end else if (m_fifo.size() > 0) begin
            e = m_fifo.pop_front();
            m_out = e[5:4];
            m_stream.delete();
            for (int k = 0; k < int'(e[3:0]); k++) m_stream.push_back(e[5:4]);
            m_active = 1;
         end else begin
            m_done = m_active;
            m_active = 0;
            m_out = 2'b00;
         end
      end
      if (can_push) m_fifo.push_back({s, rp});
   endfunction

   initial begin
      logic [1:0] fill_sym[8];
      logic       r, v, st;
      logic [1:0] s;
      logic [3:0] rp;

      // Reset, then 20 quiet cycles with no done pulse.
      add(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      // Single entry sym=10 rep=3: held after edges 1..4, done after edge 5 only.
      add(0, 1, 2'b10, 4'd3, 0, 2'b00, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      // Back-to-back (01,0),(11,1),(10,0): 01,11,11,10 then a single done.
      add(0, 1, 2'b01, 4'd0, 0, 2'b00, 0, 0, 1, 1);
      add(0, 1, 2'b11, 4'd1, 0, 2'b01, 1, 0, 1, 1);
      add(0, 1, 2'b10, 4'd0, 0, 2'b11, 1, 0, 1, 1);
      add(0, 0, 0, 0, 0, 2'b11, 1, 0, 1, 1);
      add(0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      // Stall mid-symbol: sym=11 rep=2, three stalled cycles after its first -> 6 cycles held.
      add(0, 1, 2'b11, 4'd2, 0, 2'b00, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 2'b11, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
      // Reset during the second of four queued entries: everything discarded, no done.
      add(0, 1, 2'b01, 4'd1, 0, 2'b00, 0, 0, 1, 1);
      add(0, 1, 2'b10, 4'd1, 0, 2'b01, 1, 0, 1, 1);
      add(0, 1, 2'b11, 4'd1, 0, 2'b01, 1, 0, 2, 1);
      add(0, 1, 2'b01, 4'd1, 0, 2'b10, 1, 0, 2, 1);
      add(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].vld, tbl[i].sym, tbl[i].rep, tbl[i].stl);
         chk_all($sformatf("vec%0d", i), tbl[i].e_in, tbl[i].e_busy, tbl[i].e_done,
                 tbl[i].e_level, tbl[i].e_ready);
      end

      // Fill all 8 entries under stall, try a 9th, then drain in order.
      for (int i = 0; i < 8; i++) begin
         fill_sym[i] = 2'(i + 1);
         drive(0, 1, fill_sym[i], 4'd0, 1);
         chk($sformatf("fill%0d.level", i), level, i + 1);
         chk($sformatf("fill%0d.fsm_in", i), fsm_in, 0);
      end
      chk("full.s_ready", s_ready, 0);
      drive(0, 1, 2'b11, 4'd5, 1);
      chk("ninth.level", level, 8);
      chk("ninth.s_ready", s_ready, 0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 2'b00, 4'd0, 0);
         chk($sformatf("drain%0d.fsm_in", i), fsm_in, fill_sym[i]);
         chk($sformatf("drain%0d.level", i), level, 7 - i);
         chk($sformatf("drain%0d.busy", i), busy, 1);
         chk($sformatf("drain%0d.s_ready", i), s_ready, 1);
      end
      drive(0, 0, 2'b00, 4'd0, 0);
      chk_all("drained", 0, 0, 1, 0, 1);

      // Randomized run against the model.
      for (int c = 0; c < 2000; c++) begin
         r  = (c == 0) || ($urandom_range(0, 199) == 0);
         v  = $urandom_range(0, 1);
         s  = 2'($urandom_range(0, 3));
         rp = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
         st = ($urandom_range(0, 4) == 0);
         model_step(r, v, s, rp, st);
         drive(r, v, s, rp, st);
         chk_all($sformatf("rnd%0d", c), m_out, m_active, m_done, m_fifo.size(),
                 m_fifo.size() < 8);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm_in_tx.md
Name: fsm_in_tx

Overview:
- Transmitter end of the 2-bit `in` interface of the microcoded controller FSM.
- Accepts queued (symbol, repeat) entries over a valid/ready handshake and buffers them in a small FIFO.
- Replays each symbol onto `fsm_in` for `repeat+1` cycles, back-to-back across entries, then falls back to an idle symbol.
- Drives on the rising edge so `fsm_in` is stable half a cycle before the FSM's falling-edge state update.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- REP_W, 4, width of the per-entry repeat count.
- IDLE_SYM, 2'b00, symbol driven when nothing is being played.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream entry valid.
- s_ready  out  1  FIFO not full; combinational `!full`.
- s_sym  in  2  symbol to drive.
- s_rep  in  REP_W  extra hold cycles; the symbol is driven for s_rep+1 cycles.
- stall  in  1  freeze playback: hold `fsm_in` and the remaining count.
- fsm_in  out  2  registered symbol to the FSM `in` port.
- busy  out  1  registered; 1 while in PLAY.
- done  out  1  one-cycle pulse when playback returns to idle.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, checked at a rising edge with reset=1:
  - fsm_in=IDLE_SYM, busy=0, done=0, level=0, FIFO pointers cleared, state=IDLE, remaining=0.
  - s_ready=1 in the cycle after reset.
  - Reset asserted mid-playback discards all queued entries and the current symbol. fsm_in is IDLE_SYM after that edge, and no done pulse is generated.
- Push: occurs on an edge with s_valid && s_ready. The entry becomes visible to playback from the next cycle; there is no bypass path.
- Pop and push in the same edge: level is unchanged. No push is possible when full.
- Two-state FSM, IDLE/PLAY.
- IDLE:
  - FIFO non-empty and !stall: pop head; fsm_in<=sym; remaining<=rep; go to PLAY; busy<=1.
  - Otherwise stay in IDLE with fsm_in=IDLE_SYM.
- PLAY:
  - stall=1: hold everything.
  - remaining!=0: remaining<=remaining-1.
  - remaining==0 and FIFO non-empty: pop the next entry with zero gap (fsm_in<=next sym, remaining<=next rep).
  - remaining==0 and FIFO empty: fsm_in<=IDLE_SYM; state<=IDLE; busy<=0; done<=1 for exactly one cycle.
- Latency:
  - Entry pushed at edge N into an empty, idle block appears on fsm_in after edge N+1.
  - done pulses after edge N+1+rep+1.
- Width rules:
  - remaining is REP_W bits and never underflows.
  - rep = 2^REP_W-1 gives 2^REP_W cycles of hold.
  - FIFO pointers wrap modulo DEPTH; level distinguishes full (DEPTH) from empty (0).
- Stall interaction:
  - stall on the cycle a pop would occur blocks that pop.
  - done is never asserted while stall=1.
- s_sym/s_rep are don't-care when s_valid=0.

Decomposition:
- Shared package fsm_in_pkg:
  - SYM_W=2 and the IDLE_SYM default.
  - State encoding localparams ST_IDLE=1'b0, ST_PLAY=1'b1.
  - Entry packing: {sym, rep}.
- Sub-module sym_fifo: synchronous FIFO of width 2+REP_W and depth DEPTH, providing push, pop, head data, full, empty and level.
- Playback FSM and counter live in fsm_in_tx.

Test Plan:
- Reset then idle: fsm_in=2'b00, busy=0, s_ready=1, level=0; no done pulse for 20 cycles.
- Single entry (sym=2'b10, rep=3) pushed at edge 0:
  - fsm_in=2'b10 after edges 1 through 4.
  - fsm_in=2'b00 after edge 5, with done=1 for that cycle only.
- Back-to-back entries (01,rep0), (11,rep1), (10,rep0):
  - fsm_in sequence 01,11,11,10 with no idle gap.
  - Exactly one done pulse, after the last symbol.
- Fill DEPTH=8 entries while stall=1:
  - s_ready=0 at level 8; a 9th s_valid is ignored.
  - Release stall: all 8 entries replay in order and level drains to 0.
- Stall mid-symbol (rep=2, stall for 3 cycles after its first cycle): the symbol is held for 6 cycles total, with done following afterwards.
- Reset asserted during the second of 4 queued entries: fsm_in=2'b00 next cycle; level=0, busy=0, no done pulse.
